// File: rtl/afpga_store_flash.sv
// Streams LENGTH bytes from AFPGA shared memory to the flash writer with CRC-32,
// then waits for the writer's completion and reports a done or error pulse.
module afpga_store_flash #(
  parameter logic [22:0] MEM_BASE     = 23'h400000,
  parameter logic [24:0] FLASH_ADDR   = 25'h2e400,
  parameter logic [23:0] LENGTH       = 24'h20000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [23:0] DONE_TIMEOUT = 24'hFFFFFF
) (
  input  logic        sys_clk,
  input  logic        glbl_rst,
  input  logic        flash_store_en,
  output logic        flash_store_busy,
  output logic        flash_store_done,
  output logic        flash_store_error,
  output logic        afpga_flash_wren,
  output logic [23:0] afpga_flash_length,
  output logic [24:0] afpga_flash_addr,
  output logic        store_flash_valid,
  output logic        store_flash_last,
  output logic [7:0]  store_flash_data,
  input  logic        flash_wr_ready,
  input  logic        flash_wr_done,
  input  logic        flash_wr_error,
  output logic        store_afpga_rden,
  output logic [22:0] store_afpga_addr,
  input  logic [7:0]  afpga_store_rdata,
  output logic [31:0] store_crc
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW+1:0] DepthOcc = (PtrW + 2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StStream, StWaitDone} state_e;

  state_e          state_q;
  logic            wren_q, done_q, error_q, rden_q, rvalid_q;
  logic [22:0]     addr_q;
  logic [23:0]     reads_q, bytes_q, tmo_q;
  logic [31:0]     crc_q;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;

  logic            fifo_valid, accept, push, issue;
  logic [PtrW+1:0] occ;

  function automatic logic [31:0] crc_step(logic [31:0] c, logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    fifo_valid = (cnt_q != '0);
    accept     = fifo_valid && flash_wr_ready;
    push       = rvalid_q && (state_q == StStream);
    // Reads still in the memory pipeline count against FIFO space so it can never overflow.
    occ        = {1'b0, cnt_q} + (PtrW + 2)'(rden_q) + (PtrW + 2)'(rvalid_q);
    issue      = (state_q == StStream) && (reads_q < LENGTH) && (occ < DepthOcc);
  end

  assign flash_store_busy   = (state_q != StIdle);
  assign flash_store_done   = done_q;
  assign flash_store_error  = error_q;
  assign afpga_flash_wren   = wren_q;
  assign afpga_flash_length = wren_q ? LENGTH : 24'd0;
  assign afpga_flash_addr   = wren_q ? FLASH_ADDR : 25'd0;
  assign store_flash_valid  = fifo_valid;
  assign store_flash_data   = fifo_valid ? fifo_q[rd_ptr_q] : 8'd0;
  assign store_flash_last   = fifo_valid && (bytes_q == LENGTH - 24'd1);
  assign store_afpga_rden   = rden_q;
  assign store_afpga_addr   = addr_q;
  assign store_crc          = ~crc_q;

  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_q  <= StIdle;
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rden_q   <= 1'b0;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      reads_q  <= '0;
      bytes_q  <= '0;
      tmo_q    <= '0;
      crc_q    <= '1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rden_q   <= issue;
      rvalid_q <= rden_q;
      if (rden_q) addr_q <= addr_q + 23'd1;
      if (issue) reads_q <= reads_q + 24'd1;
      if (push) begin
        fifo_q[wr_ptr_q] <= afpga_store_rdata;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (accept) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        bytes_q  <= bytes_q + 24'd1;
        crc_q    <= crc_step(crc_q, fifo_q[rd_ptr_q]);
      end
      cnt_q <= cnt_q + (PtrW + 1)'(push) - (PtrW + 1)'(accept);

      case (state_q)
        StIdle: begin
          if (flash_store_en) begin
            state_q <= StReq;
            wren_q  <= 1'b1;
            crc_q   <= '1;
            addr_q  <= MEM_BASE;
            reads_q <= '0;
            bytes_q <= '0;
          end
        end
        StReq: begin
          if (LENGTH == 24'd0) begin
            error_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (flash_wr_error) begin
            error_q  <= 1'b1;
            state_q  <= StIdle;
            rden_q   <= 1'b0;
            rvalid_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
          end else if (accept && store_flash_last) begin
            state_q <= StWaitDone;
            // tmo_q counts cycles since the accepting cycle.
            tmo_q   <= 24'd1;
          end
        end
        StWaitDone: begin
          tmo_q <= tmo_q + 24'd1;
          if (flash_wr_error || (tmo_q == DONE_TIMEOUT - 24'd1)) begin
            error_q <= 1'b1;
            state_q <= StIdle;
          end else if (flash_wr_done) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
